multi_bus_sync: RTL and testbench
=================================

// Module: multi_bus_sync
// PURPOSE
//  Multi-channel, single-clock capture of multi-bit buses that change slowly relative to clk
//  (e.g. slow-domain registers read into the Nios fast domain). Per channel: an N-stage sync
//  chain plus a stability qualifier. The output bus is updated only after the synchronised value
//  has held for STABLE_CYCLES consecutive clocks, so a torn/mid-transition word never propagates.
//  Each committed update raises a one-cycle update_pulse.
// PARAMETERS
//  W              12   data bits per channel
//  CH             1    number of independent channels
//  SYNC_STAGES    2    flops in each sync chain (>=2; elaboration error otherwise)
//  STABLE_CYCLES  3    consecutive equal synchronised samples required to commit
//                      (>=2; elaboration error otherwise)
// PORTS
//  clk           in   1      single clock; all logic on posedge
//  reset_n       in   1      asynchronous, active-low reset
//  async_data    in   CH*W   unsynchronised input buses; channel c = [c*W +: W]
//  sync_data     out  CH*W   qualified, synchronised output buses
//  update_pulse  out  CH     1-cycle pulse per channel on each commit
//  settling      out  CH     channel is in SETTLE (candidate pending)
//  evt_cnt       out  CH*16  only with SYNC_EVENT_CNT_EN (see CONFIGURATION)
// BEHAVIOUR
//  Reset (reset_n low, async assert, sync release via normal flops): sync chains, cand, cnt,
//    sync_data, update_pulse, settling, and evt_cnt all clear to 0; FSM goes to IDLE.
//  s = last sync-chain stage. cnt is $clog2(STABLE_CYCLES+1) bits wide.
//  Per-channel FSM {IDLE, SETTLE}:
//   IDLE:   s==sync_data -> stay. s!=sync_data -> cand<=s, cnt<=1, SETTLE.
//   SETTLE: s==cand and cnt==STABLE_CYCLES-1 -> sync_data<=cand, update_pulse<=1 next cycle, IDLE.
//           s==cand, cnt lower -> cnt<=cnt+1.
//           s!=cand and s==sync_data -> IDLE, no update (glitch rejected).
//           s!=cand and s!=sync_data -> cand<=s, cnt<=1 (restart on new value).
//  Latency: value first captured by stage 0 at edge E0 and held stable ->
//    sync_data changes at edge E0+SYNC_STAGES+STABLE_CYCLES-1; update_pulse high for that cycle.
//    Defaults: 4 edges.
//  Continuously changing input -> sync_data holds its last committed value indefinitely.
//  update_pulse is never high 2 cycles in a row. Minimum spacing between pulses is
//    STABLE_CYCLES cycles.
//  settling is a registered copy of (state==SETTLE).
//  Channels are fully independent; simultaneous commits on several channels are allowed.
//  Reset mid-SETTLE: candidate discarded, sync_data returns to 0, no pulse.
// CONFIGURATION
//  SYNC_EVENT_CNT_EN defined:
//   - port evt_cnt exists; per channel, a 16-bit saturating count of commits.
//   - Saturates at 16'hFFFF; no wrap.
//  SYNC_EVENT_CNT_EN undefined:
//   - port evt_cnt and its counters are absent; all other behaviour is identical.
// STRUCTURE
//  Package bus_sync_pkg:
//   - typedef enum logic {IDLE, SETTLE} bus_sync_state_t
//   - localparam EVT_CNT_W = 16
//   - function cnt_w(n) = $clog2(n+1)
//  Sub-module bus_sync_channel (#W, SYNC_STAGES, STABLE_CYCLES): one chain + FSM + optional counter.
//  Top level instantiates CH channels in a generate loop; no logic is shared between channels.
// TESTING
//  1. Reset with async_data=12'hABC, release, hold -> sync_data=0 until edge 4 after the first
//     stage-0 capture, then 12'hABC with a single update_pulse.
//  2. Step 12'h000->12'h5A5, held -> exactly one pulse; sync_data=12'h5A5 after 4 edges; settling
//     high for the 2 prior cycles.
//  3. 1-cycle glitch 12'h000->12'hFFF->12'h000 -> no pulse, sync_data stays 12'h000; settling
//     goes high, then drops.
//  4. Input toggles 12'h111/12'h222 every cycle for 50 cycles, then holds 12'h222 -> no pulse
//     during toggling; exactly one commit to 12'h222.
//  5. CH=4: distinct held values on each channel at staggered times -> each channel commits
//     independently with correct latency; no cross-talk.
//  6. SYNC_EVENT_CNT_EN: 3 commits -> evt_cnt=3; reset_n low mid-SETTLE -> all outputs 0
//     immediately; counter saturation forced -> 16'hFFFF holds.

Source files
------------

// File: rtl/bus_sync_pkg.sv
// Shared types and sizing helpers for the multi-channel slow-bus synchroniser.
// Optional commit counters are enabled by defining SYNC_EVENT_CNT_EN.
package bus_sync_pkg;

  typedef enum logic {IDLE, SETTLE} bus_sync_state_t;

  localparam int EVT_CNT_W = 16;

  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bus_sync_channel.sv
// One channel: N-flop sync chain, then a stability qualifier that commits a word only after it holds.
// SYNC_EVENT_CNT_EN adds a 16-bit saturating count of commits on port evt_cnt.
module bus_sync_channel
  import bus_sync_pkg::*;
#(
  parameter int W             = 12,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [W-1:0]         async_data,
  output logic [W-1:0]         sync_data,
  output logic                 update_pulse,
  output logic                 settling
`ifdef SYNC_EVENT_CNT_EN
  ,
  output logic [EVT_CNT_W-1:0] evt_cnt
`endif
);

  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("bus_sync_channel: SYNC_STAGES must be >= 2");
  end
  if (STABLE_CYCLES < 2) begin : g_bad_stable_cycles
    $error("bus_sync_channel: STABLE_CYCLES must be >= 2");
  end

  localparam int CNT_W = cnt_w(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0][W-1:0] chain;
  logic [W-1:0]                  s;
  bus_sync_state_t               state_q, state_d;
  logic [W-1:0]                  cand_q, cand_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [W-1:0]                  data_q, data_d;
  logic                          pulse_q, pulse_d;
  logic                          settling_q;

  assign s = chain[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], async_data};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cand_q     <= '0;
      cnt_q      <= '0;
      data_q     <= '0;
      pulse_q    <= 1'b0;
      settling_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      pulse_q    <= pulse_d;
      settling_q <= (state_d == SETTLE);
    end
  end

  // A candidate that falls back to the committed word is a rejected glitch;
  // any other new value restarts the stability count.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (s != data_q) begin
          cand_d  = s;
          cnt_d   = CNT_ONE;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (s == cand_q) begin
          if (cnt_q == CNT_LAST) begin
            data_d  = cand_q;
            pulse_d = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else if (s == data_q) begin
          state_d = IDLE;
        end else begin
          cand_d = s;
          cnt_d  = CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sync_data    = data_q;
  assign update_pulse = pulse_q;
  assign settling     = settling_q;

`ifdef SYNC_EVENT_CNT_EN
  logic [EVT_CNT_W-1:0] evt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      evt_q <= '0;
    end else if (pulse_d && (evt_q != {EVT_CNT_W{1'b1}})) begin
      evt_q <= evt_q + EVT_CNT_W'(1);
    end
  end

  assign evt_cnt = evt_q;
`endif

endmodule

// File: rtl/multi_bus_sync.sv
// Top level: CH fully independent bus_sync_channel instances on one clock.
// SYNC_EVENT_CNT_EN exposes the per-channel commit counters on evt_cnt.
module multi_bus_sync
  import bus_sync_pkg::*;
#(
  parameter int W             = 12,
  parameter int CH            = 1,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [CH*W-1:0]         async_data,
  output logic [CH*W-1:0]         sync_data,
  output logic [CH-1:0]           update_pulse,
  output logic [CH-1:0]           settling
`ifdef SYNC_EVENT_CNT_EN
  ,
  output logic [CH*EVT_CNT_W-1:0] evt_cnt
`endif
);

  for (genvar c = 0; c < CH; c++) begin : g_ch
    bus_sync_channel #(
      .W             (W),
      .SYNC_STAGES   (SYNC_STAGES),
      .STABLE_CYCLES (STABLE_CYCLES)
    ) u_ch (
      .clk          (clk),
      .reset_n      (reset_n),
      .async_data   (async_data[c*W +: W]),
      .sync_data    (sync_data[c*W +: W]),
      .update_pulse (update_pulse[c]),
      .settling     (settling[c])
`ifdef SYNC_EVENT_CNT_EN
      ,
      .evt_cnt      (evt_cnt[c*EVT_CNT_W +: EVT_CNT_W])
`endif
    );
  end

endmodule

// File: tb/tb_multi_bus_sync.sv
// Self-checking bench for multi_bus_sync (CH=4, defaults otherwise) against a run-length reference model.
// Evt_cnt checks are included when SYNC_EVENT_CNT_EN is defined.
module tb_multi_bus_sync;

  localparam int W  = 12;
  localparam int CH = 4;
  localparam int SS = 2;
  localparam int SC = 3;
  localparam int HN = 4096;

  logic            clk;
  logic            reset_n;
  logic [CH*W-1:0] async_data;
  logic [CH*W-1:0] sync_data;
  logic [CH-1:0]   update_pulse;
  logic [CH-1:0]   settling;
`ifdef SYNC_EVENT_CNT_EN
  logic [CH*16-1:0] evt_cnt;
`endif

  multi_bus_sync #(
    .W             (W),
    .CH            (CH),
    .SYNC_STAGES   (SS),
    .STABLE_CYCLES (SC)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .async_data   (async_data),
    .sync_data    (sync_data),
    .update_pulse (update_pulse),
    .settling     (settling)
`ifdef SYNC_EVENT_CNT_EN
    ,
    .evt_cnt      (evt_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: every edge records the input word; the qualifier sees it SS edges later,
  // and a commit happens when the last SC seen words agree and differ from the committed word.
  logic [W-1:0] hist [CH][HN];
  logic [W-1:0] m_sync [CH];
  logic         m_pulse [CH];
  logic         m_settle [CH];
  int           m_evt [CH];
  int           nedge;
  int           obs_pulses [CH];
  int           checks;
  int           failures;

  function automatic logic [W-1:0] seen_at(input int c, input int t);
    if (t - SS < 0) return '0;
    return hist[c][(t - SS) % HN];
  endfunction

  task automatic model_reset();
    nedge = 0;
    for (int c = 0; c < CH; c++) begin
      m_sync[c]   = '0;
      m_pulse[c]  = 1'b0;
      m_settle[c] = 1'b0;
      m_evt[c]    = 0;
    end
  endtask

  task automatic check_output(input string tag);
    logic [CH*W-1:0] exp_d;
    logic [CH-1:0]   exp_p;
    logic [CH-1:0]   exp_s;
`ifdef SYNC_EVENT_CNT_EN
    logic [CH*16-1:0] exp_e;
`endif
    for (int c = 0; c < CH; c++) begin
      exp_d[c*W +: W] = m_sync[c];
      exp_p[c]        = m_pulse[c];
      exp_s[c]        = m_settle[c];
`ifdef SYNC_EVENT_CNT_EN
      exp_e[c*16 +: 16] = 16'(m_evt[c]);
`endif
    end
    checks++;
    assert (sync_data === exp_d) else begin
      failures++;
      $error("[TB] FAIL %s sync_data edge=%0d got=%h exp=%h", tag, nedge, sync_data, exp_d);
    end
    checks++;
    assert (update_pulse === exp_p) else begin
      failures++;
      $error("[TB] FAIL %s update_pulse edge=%0d got=%b exp=%b", tag, nedge, update_pulse, exp_p);
    end
    checks++;
    assert (settling === exp_s) else begin
      failures++;
      $error("[TB] FAIL %s settling edge=%0d got=%b exp=%b", tag, nedge, settling, exp_s);
    end
`ifdef SYNC_EVENT_CNT_EN
    checks++;
    assert (evt_cnt === exp_e) else begin
      failures++;
      $error("[TB] FAIL %s evt_cnt edge=%0d got=%h exp=%h", tag, nedge, evt_cnt, exp_e);
    end
`endif
  endtask

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_ch(input int c, input logic [W-1:0] v);
    async_data[c*W +: W] = v;
  endtask

  // One clock edge: record inputs, advance the model, then compare just after the edge.
  task automatic apply_stimulus(input string tag);
    logic [W-1:0] v;
    logic         commit;
    @(posedge clk);
    for (int c = 0; c < CH; c++) hist[c][nedge % HN] = async_data[c*W +: W];
    for (int c = 0; c < CH; c++) begin
      v      = seen_at(c, nedge);
      commit = (v != m_sync[c]);
      for (int k = 1; k < SC; k++) if (seen_at(c, nedge - k) != v) commit = 1'b0;
      m_pulse[c] = commit;
      if (commit) begin
        m_sync[c] = v;
        if (m_evt[c] < 16'hFFFF) m_evt[c]++;
      end
      m_settle[c] = (v != m_sync[c]);
    end
    nedge++;
    #1;
    for (int c = 0; c < CH; c++) obs_pulses[c] += int'(update_pulse[c]);
    check_output(tag);
  endtask

  task automatic clear_pulse_counts();
    for (int c = 0; c < CH; c++) obs_pulses[c] = 0;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    reset_n    = 1'b0;
    async_data = '0;
    clear_pulse_counts();
    model_reset();
    set_ch(0, 12'hABC);

    // Reset state, then first capture of a value held through reset release.
    #2;
    check_output("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) apply_stimulus("t1");
    check_val("t1_before_commit", 64'(sync_data[11:0]), 64'h0);
    apply_stimulus("t1");
    check_val("t1_commit", 64'(sync_data[11:0]), 64'hABC);
    check_val("t1_pulse", 64'(update_pulse[0]), 64'h1);
    apply_stimulus("t1");
    check_val("t1_pulse_single", 64'(update_pulse[0]), 64'h0);

    // Step 000 -> 5A5.
    set_ch(0, 12'h000);
    repeat (8) apply_stimulus("t2_pre");
    clear_pulse_counts();
    set_ch(0, 12'h5A5);
    repeat (4) apply_stimulus("t2");
    check_val("t2_settling", 64'(settling[0]), 64'h1);
    check_val("t2_hold_old", 64'(sync_data[11:0]), 64'h000);
    apply_stimulus("t2");
    check_val("t2_commit", 64'(sync_data[11:0]), 64'h5A5);
    check_val("t2_settle_drop", 64'(settling[0]), 64'h0);
    repeat (4) apply_stimulus("t2");
    check_val("t2_one_pulse", 64'(obs_pulses[0]), 64'd1);

    // Single-cycle glitch is rejected.
    set_ch(0, 12'h000);
    repeat (8) apply_stimulus("t3_pre");
    clear_pulse_counts();
    set_ch(0, 12'hFFF);
    apply_stimulus("t3");
    set_ch(0, 12'h000);
    repeat (8) apply_stimulus("t3");
    check_val("t3_no_pulse", 64'(obs_pulses[0]), 64'd0);
    check_val("t3_value", 64'(sync_data[11:0]), 64'h000);

    // Continuously toggling input never commits; the final held value commits once.
    clear_pulse_counts();
    for (int i = 0; i < 50; i++) begin
      set_ch(0, (i % 2 == 0) ? 12'h111 : 12'h222);
      apply_stimulus("t4_toggle");
    end
    check_val("t4_no_pulse_toggle", 64'(obs_pulses[0]), 64'd0);
    set_ch(0, 12'h222);
    repeat (8) apply_stimulus("t4_hold");
    check_val("t4_one_commit", 64'(obs_pulses[0]), 64'd1);
    check_val("t4_value", 64'(sync_data[11:0]), 64'h222);

    // Staggered, distinct values on every channel.
    for (int c = 0; c < CH; c++) begin
      set_ch(c, 12'(12'h123 + c * 12'h211));
      repeat (2) apply_stimulus("t5");
    end
    repeat (8) apply_stimulus("t5");
    for (int c = 0; c < CH; c++)
      check_val("t5_channel", 64'(sync_data[c*W +: W]), 64'(12'h123 + c * 12'h211));

    // Asynchronous reset while every channel is settling.
    for (int c = 0; c < CH; c++) set_ch(c, 12'(12'h7C0 + c));
    repeat (3) apply_stimulus("t6_pre");
    check_val("t6_settling_before_reset", 64'(settling), 64'hF);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_output("t6_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Randomised phase: held words, random changes and short glitches on all channels.
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 5) == 0) set_ch(c, 12'($urandom));
      end
      apply_stimulus("rand");
    end
    for (int c = 0; c < CH; c++) set_ch(c, 12'($urandom));
    repeat (8) apply_stimulus("rand_settle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
